// File: rtl/alu_defs.sv
// Shared definitions for the ALU arbiter: op codes, FSM states, condition codes.
package alu_defs;

  localparam int unsigned DATA_W = 64;
  localparam int unsigned FN_W   = 2;

  localparam logic [FN_W-1:0] FN_ADD = 2'd0;
  localparam logic [FN_W-1:0] FN_SUB = 2'd1;
  localparam logic [FN_W-1:0] FN_AND = 2'd2;
  localparam logic [FN_W-1:0] FN_XOR = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  typedef struct packed {
    logic zf;
    logic sf;
    logic of;
  } cc_t;

  localparam cc_t CC_RESET = '{zf: 1'b1, sf: 1'b0, of: 1'b0};

endpackage

// File: rtl/alu64.sv
// Combinational 64-bit ALU: add/sub (b op a), and, xor, with condition flags.
module alu64
  import alu_defs::*;
(
  input  logic [FN_W-1:0]   fn,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zf,
  output logic              sf,
  output logic              of
);

  localparam int unsigned MSB = DATA_W - 1;

  // Operation select and overflow detection from operand/result signs.
  always_comb begin
    result = '0;
    of     = 1'b0;
    case (fn)
      FN_ADD: begin
        result = b + a;
        of     = (a[MSB] == b[MSB]) && (result[MSB] != a[MSB]);
      end
      FN_SUB: begin
        result = b - a;
        of     = (a[MSB] != b[MSB]) && (result[MSB] != b[MSB]);
      end
      FN_AND: result = a & b;
      default: result = a ^ b;
    endcase
    zf = (result == '0);
    sf = result[MSB];
  end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester round-robin front end to a shared 64-bit ALU, one op per 3 cycles.
module alu_arbiter
  import alu_defs::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                req0,
  input  logic                req1,
  input  logic [FN_W-1:0]     fn0,
  input  logic [FN_W-1:0]     fn1,
  input  logic [DATA_W-1:0]   a0,
  input  logic [DATA_W-1:0]   b0,
  input  logic [DATA_W-1:0]   a1,
  input  logic [DATA_W-1:0]   b1,
  input  logic                setcc0,
  input  logic                setcc1,
  output logic                gnt0,
  output logic                gnt1,
  output logic                done0,
  output logic                done1,
  output logic [DATA_W-1:0]   result,
  output logic                zf,
  output logic                sf,
  output logic                of
);

  state_t              r_state, w_state_nxt;
  logic                r_last, w_last_nxt;
  logic                r_owner, w_owner_nxt;
  logic [FN_W-1:0]     r_fn, w_fn_nxt;
  logic [DATA_W-1:0]   r_a, w_a_nxt;
  logic [DATA_W-1:0]   r_b, w_b_nxt;
  logic                r_sc, w_sc_nxt;
  logic                r_gnt0, w_gnt0_nxt;
  logic                r_gnt1, w_gnt1_nxt;
  logic                r_done0, w_done0_nxt;
  logic                r_done1, w_done1_nxt;
  logic [DATA_W-1:0]   r_result, w_result_nxt;
  cc_t                 r_cc, w_cc_nxt;

  logic                w_pick1;
  logic [DATA_W-1:0]   w_alu_result;
  cc_t                 w_alu_cc;

  // Requester 1 wins when alone, or on a tie when requester 0 was served last.
  assign w_pick1 = req1 && (!req0 || !r_last);

  alu64 u_alu (
    .fn     (r_fn),
    .a      (r_a),
    .b      (r_b),
    .result (w_alu_result),
    .zf     (w_alu_cc.zf),
    .sf     (w_alu_cc.sf),
    .of     (w_alu_cc.of)
  );

  // Next-state and next-output logic for the IDLE/EXEC/RESP sequence.
  always_comb begin
    w_state_nxt  = r_state;
    w_last_nxt   = r_last;
    w_owner_nxt  = r_owner;
    w_fn_nxt     = r_fn;
    w_a_nxt      = r_a;
    w_b_nxt      = r_b;
    w_sc_nxt     = r_sc;
    w_gnt0_nxt   = 1'b0;
    w_gnt1_nxt   = 1'b0;
    w_done0_nxt  = 1'b0;
    w_done1_nxt  = 1'b0;
    w_result_nxt = r_result;
    w_cc_nxt     = r_cc;
    case (r_state)
      ST_IDLE: begin
        if (req0 || req1) begin
          w_owner_nxt = w_pick1;
          w_last_nxt  = w_pick1;
          w_fn_nxt    = w_pick1 ? fn1 : fn0;
          w_a_nxt     = w_pick1 ? a1 : a0;
          w_b_nxt     = w_pick1 ? b1 : b0;
          w_sc_nxt    = w_pick1 ? setcc1 : setcc0;
          w_gnt0_nxt  = !w_pick1;
          w_gnt1_nxt  = w_pick1;
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_result_nxt = w_alu_result;
        if (r_sc) begin
          w_cc_nxt = w_alu_cc;
        end
        w_done0_nxt = !r_owner;
        w_done1_nxt = r_owner;
        w_state_nxt = ST_RESP;
      end
      ST_RESP: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // State, latched operands and registered outputs; reset aborts any op in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_owner  <= 1'b0;
      r_fn     <= FN_ADD;
      r_a      <= '0;
      r_b      <= '0;
      r_sc     <= 1'b0;
      r_gnt0   <= 1'b0;
      r_gnt1   <= 1'b0;
      r_done0  <= 1'b0;
      r_done1  <= 1'b0;
      r_result <= '0;
      r_cc     <= CC_RESET;
    end else begin
      r_state  <= w_state_nxt;
      r_last   <= w_last_nxt;
      r_owner  <= w_owner_nxt;
      r_fn     <= w_fn_nxt;
      r_a      <= w_a_nxt;
      r_b      <= w_b_nxt;
      r_sc     <= w_sc_nxt;
      r_gnt0   <= w_gnt0_nxt;
      r_gnt1   <= w_gnt1_nxt;
      r_done0  <= w_done0_nxt;
      r_done1  <= w_done1_nxt;
      r_result <= w_result_nxt;
      r_cc     <= w_cc_nxt;
    end
  end

  assign gnt0   = r_gnt0;
  assign gnt1   = r_gnt1;
  assign done0  = r_done0;
  assign done1  = r_done1;
  assign result = r_result;
  assign zf     = r_cc.zf;
  assign sf     = r_cc.sf;
  assign of     = r_cc.of;

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-high.
REQ-002 Port list SHALL be exactly:
- clk  in  1  rising-edge clock
- rst  in  1  sync active-high reset
- req0, req1  in  1 each  operation request, requester 0 (execute) / 1 (address calc)
- fn0, fn1  in  2 each  op code: 0 add (b+a), 1 sub (b-a), 2 and, 3 xor
- a0, b0, a1, b1  in  64 each  operands, two's complement
- setcc0, setcc1  in  1 each  update condition codes on completion
- gnt0, gnt1  out  1 each  one-cycle grant pulse
- done0, done1  out  1 each  one-cycle completion pulse
- result  out  64  registered ALU result
- zf, sf, of  out  1 each  condition code register

Function
REQ-003 FSM states SHALL be IDLE, EXEC, RESP.
REQ-004 In IDLE, at a clock edge with req0 or req1 high, the block SHALL latch the winner's fn, a, b and setcc, set the winner's gnt, and go to EXEC.
REQ-005 In IDLE with no request, the block SHALL stay in IDLE with all pulses low.
REQ-006 Arbitration SHALL be round-robin: a single request wins; with both high, the requester not served last wins.
REQ-007 In EXEC (gnt high), at the next edge the block SHALL register result, update CCs if latched setcc=1, drop gnt, set the matching done, and go to RESP.
REQ-008 In RESP (done high), at the next edge the block SHALL drop done and return to IDLE.
REQ-009 Timing: request sampled at edge e0 -> gnt high for cycle after e0 -> done/result valid for cycle after e0+1 -> IDLE samples again at e0+3; one op per 3 cycles.
REQ-010 Requests SHALL NOT be sampled in EXEC or RESP.
REQ-011 A requester SHALL hold req, fn and operands until it sees its gnt; operands SHALL NOT be needed after the grant edge.
REQ-012 A req still high when the block returns to IDLE SHALL be treated as a new request.
REQ-013 result SHALL hold its value until the next completion.
REQ-014 Arithmetic SHALL be modulo 2^64.
REQ-015 ZF SHALL equal (result==0); SF SHALL equal result[63].
REQ-016 OF for add SHALL be set when a and b have equal sign and result sign differs from it.
REQ-017 OF for sub SHALL be set when a and b have different sign and result sign differs from b's sign.
REQ-018 OF SHALL be 0 for and/xor.
REQ-019 With setcc=0, zf, sf and of SHALL be unchanged.
REQ-020 The block SHALL never assert gnt0 and gnt1 together, nor done0 and done1 together.

Reset
REQ-021 On rst the block SHALL set state IDLE, gnt0/1=0, done0/1=0, result=0, zf=1, sf=0, of=0, last-served=requester 1 (requester 0 wins the first tie).
REQ-022 Reset in EXEC or RESP SHALL abort the operation: no done pulse, no CC update.
REQ-023 Reset SHALL override any request present in the same cycle.

Structure
REQ-024 The shared package alu_defs SHALL hold the fn encodings, the FSM state encoding and the CC reset value.
REQ-025 The block SHALL instantiate one combinational sub-module alu64 (inputs fn, a, b; outputs result, zf, sf, of).
REQ-026 The arbiter/FSM SHALL stay in alu_arbiter.

Verification
REQ-027 req0, fn0=0, a0=5, b0=7, setcc0=1 -> gnt0 next cycle; done0 and result=12 the cycle after; zf=0, sf=0, of=0.
REQ-028 After reset, req0 and req1 held high together -> grants in order 0,1,0,1; gnt and done each strictly alternate between requesters.
REQ-029 req1, fn1=1, b1=0x8000000000000000, a1=1, setcc1=1 -> result=0x7FFFFFFFFFFFFFFF, of=1, sf=0, zf=0.
REQ-030 fn0=3, a0=b0=0xDEADBEEF, setcc0=0 following the REQ-029 op -> result=0, CCs unchanged (of=1).
REQ-031 rst asserted in EXEC -> no done pulse; zf=1, sf=0, of=0; next req1 granted from IDLE normally.
